// File: rtl/pipe_err_monitor.sv
// Pipeline health monitor: sticky encoded error, halt tracking, stats.
// Ports: clk, rst (sync active-high), retire, halt, stall, src_err[3:0],
//    err, err_code[2:0], halted, retire_cnt, stall_cnt [CNT_W-1:0].
module pipe_err_monitor #(
   parameter int WDOG_CYCLES = 1024,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             retire,
   input  logic             halt,
   input  logic             stall,
   input  logic [3:0]       src_err,
   output logic             err,
   output logic [2:0]       err_code,
   output logic             halted,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      S_RUN,
      S_HALTED,
      S_ERROR
   } state_t;

   localparam logic [15:0] WDOG_MAX = 16'(WDOG_CYCLES - 1);

   state_t      state;
   logic [15:0] wdog;
   logic        fault;
   logic [2:0]  code;

   // RUN-state fault detection, highest priority first
   always_comb begin
      fault = 1'b1;
      code  = 3'd0;
      if (src_err[0])
         code = 3'd1;
      else if (src_err[1])
         code = 3'd2;
      else if (src_err[2])
         code = 3'd3;
      else if (src_err[3])
         code = 3'd4;
      else if (halt && !retire)
         code = 3'd7;
      else if (!retire && wdog == WDOG_MAX)
         code = 3'd5;
      else
         fault = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RUN;
         err        <= 1'b0;
         err_code   <= 3'd0;
         halted     <= 1'b0;
         retire_cnt <= '0;
         stall_cnt  <= '0;
         wdog       <= '0;
      end else begin
         unique case (state)
            S_RUN: begin
               if (fault) begin
                  state    <= S_ERROR;
                  err      <= 1'b1;
                  err_code <= code;
               end else begin
                  wdog <= retire ? 16'd0 : wdog + 16'd1;
                  if (retire && retire_cnt != '1)
                     retire_cnt <= retire_cnt + CNT_W'(1);
                  if (stall && stall_cnt != '1)
                     stall_cnt <= stall_cnt + CNT_W'(1);
                  if (retire && halt) begin
                     state  <= S_HALTED;
                     halted <= 1'b1;
                  end
               end
            end
            S_HALTED: begin
               // nothing may retire once HALT has committed
               if (retire) begin
                  state    <= S_ERROR;
                  err      <= 1'b1;
                  err_code <= 3'd6;
                  halted   <= 1'b0;
               end
            end
            S_ERROR: begin
               state <= S_ERROR;
            end
            default: begin
               state <= S_ERROR;
               err   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_err_monitor.sv
// Self-checking bench for pipe_err_monitor (WDOG_CYCLES=8, CNT_W=4).
// Table-driven vectors plus directed multi-cycle sequences.
module tb_pipe_err_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       retire;
   logic       halt;
   logic       stall;
   logic [3:0] src_err;
   logic       err;
   logic [2:0] err_code;
   logic       halted;
   logic [3:0] retire_cnt;
   logic [3:0] stall_cnt;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   pipe_err_monitor #(
      .WDOG_CYCLES(8),
      .CNT_W      (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .retire    (retire),
      .halt      (halt),
      .stall     (stall),
      .src_err   (src_err),
      .err       (err),
      .err_code  (err_code),
      .halted    (halted),
      .retire_cnt(retire_cnt),
      .stall_cnt (stall_cnt)
   );

   typedef struct {
      logic       rst;
      logic       retire;
      logic       halt;
      logic       stall;
      logic [3:0] src;
      logic       e_err;
      logic [2:0] e_code;
      logic       e_halted;
      logic [3:0] e_rc;
      logic [3:0] e_sc;
   } vec_t;

   localparam int NV = 19;
   vec_t vt[NV];

   function automatic vec_t mk(
      input logic r, input logic rt, input logic h,
      input logic s, input logic [3:0] se,
      input logic ee, input logic [2:0] ec,
      input logic eh, input logic [3:0] erc,
      input logic [3:0] esc);
      vec_t v;
      v.rst = r; v.retire = rt; v.halt = h;
      v.stall = s; v.src = se;
      v.e_err = ee; v.e_code = ec;
      v.e_halted = eh; v.e_rc = erc; v.e_sc = esc;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      else
         passed++;
   endtask

   task automatic chk_all(input string tag,
                          input logic ee,
                          input logic [2:0] ec,
                          input logic eh,
                          input logic [3:0] erc,
                          input logic [3:0] esc);
      chk({tag, ".err"}, 32'(err), 32'(ee));
      chk({tag, ".code"}, 32'(err_code), 32'(ec));
      chk({tag, ".halted"}, 32'(halted), 32'(eh));
      chk({tag, ".rcnt"}, 32'(retire_cnt), 32'(erc));
      chk({tag, ".scnt"}, 32'(stall_cnt), 32'(esc));
   endtask

   task automatic drive(input logic r, input logic rt,
                        input logic h, input logic s,
                        input logic [3:0] se);
      rst = r; retire = rt; halt = h;
      stall = s; src_err = se;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   initial begin
      rst = 1'b1; retire = 1'bx; halt = 1'bx;
      stall = 1'bx; src_err = 4'bxxxx;
      @(posedge clk);
      #1;
      chk_all("xrst", 1'b0, 3'd0, 1'b0, 4'd0, 4'd0);

      vt[0]  = mk(1,0,0,0,4'h0, 0,3'd0,0,4'd0,4'd0);
      vt[1]  = mk(0,1,0,1,4'h0, 0,3'd0,0,4'd1,4'd1);
      vt[2]  = mk(0,0,0,1,4'h0, 0,3'd0,0,4'd1,4'd2);
      vt[3]  = mk(0,1,0,1,4'ha, 1,3'd2,0,4'd1,4'd2);
      vt[4]  = mk(0,0,0,0,4'h1, 1,3'd2,0,4'd1,4'd2);
      vt[5]  = mk(1,0,0,0,4'h0, 0,3'd0,0,4'd0,4'd0);
      vt[6]  = mk(0,1,1,0,4'h8, 1,3'd4,0,4'd0,4'd0);
      vt[7]  = mk(1,0,0,0,4'h0, 0,3'd0,0,4'd0,4'd0);
      vt[8]  = mk(0,0,1,0,4'h0, 1,3'd7,0,4'd0,4'd0);
      vt[9]  = mk(1,0,0,0,4'h0, 0,3'd0,0,4'd0,4'd0);
      vt[10] = mk(0,0,0,0,4'h4, 1,3'd3,0,4'd0,4'd0);
      vt[11] = mk(1,0,0,0,4'h0, 0,3'd0,0,4'd0,4'd0);
      vt[12] = mk(0,0,0,0,4'hc, 1,3'd3,0,4'd0,4'd0);
      vt[13] = mk(1,0,0,0,4'h0, 0,3'd0,0,4'd0,4'd0);
      vt[14] = mk(0,1,1,0,4'h0, 0,3'd0,1,4'd1,4'd0);
      vt[15] = mk(0,0,1,1,4'hf, 0,3'd0,1,4'd1,4'd0);
      vt[16] = mk(0,1,0,0,4'h0, 1,3'd6,0,4'd1,4'd0);
      vt[17] = mk(0,1,1,1,4'h1, 1,3'd6,0,4'd1,4'd0);
      vt[18] = mk(1,0,0,0,4'h0, 0,3'd0,0,4'd0,4'd0);

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].rst, vt[i].retire, vt[i].halt,
               vt[i].stall, vt[i].src);
         chk_all($sformatf("v%0d", i), vt[i].e_err,
                 vt[i].e_code, vt[i].e_halted,
                 vt[i].e_rc, vt[i].e_sc);
      end

      // ten retires then HALT, followed by a long idle stretch
      do_reset();
      for (int i = 0; i < 10; i++)
         drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      chk_all("halt11", 1'b0, 3'd0, 1'b1, 4'd11, 4'd0);
      for (int i = 0; i < 50; i++)
         drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("idle50", 1'b0, 3'd0, 1'b1, 4'd11, 4'd0);

      // watchdog: 8 consecutive no-retire cycles
      do_reset();
      for (int i = 0; i < 7; i++)
         drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      chk_all("wd7", 1'b0, 3'd0, 1'b0, 4'd0, 4'd7);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      chk_all("wd8", 1'b1, 3'd5, 1'b0, 4'd0, 4'd7);

      // a retire on cycle 7 restarts the count
      do_reset();
      for (int i = 0; i < 6; i++)
         drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 7; i++)
         drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("wdr7", 1'b0, 3'd0, 1'b0, 4'd1, 4'd6);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      chk_all("wdr8", 1'b1, 3'd5, 1'b0, 4'd1, 4'd6);

      // counter saturation at 4 bits
      do_reset();
      for (int i = 0; i < 20; i++)
         drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
      chk_all("sat", 1'b0, 3'd0, 1'b0, 4'd15, 4'd15);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
